// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if: start/stop control, quasi-static registers and status of the trigger sequencer
interface trigger_sequencer_if #(parameter int B = 32, parameter int NB = 16);
  logic start;
  logic stop;
  logic [B-1:0] DELAY_REG;
  logic [B-1:0] WIDTH_REG;
  logic [B-1:0] PERIOD_REG;
  logic [NB-1:0] NPULSE_REG;
  logic trig;
  logic busy;
  logic done;
  logic [NB-1:0] pulse_cnt;
  modport master(output start, stop, DELAY_REG, WIDTH_REG, PERIOD_REG, NPULSE_REG, input trig, busy, done, pulse_cnt);
  modport slave(input start, stop, DELAY_REG, WIDTH_REG, PERIOD_REG, NPULSE_REG, output trig, busy, done, pulse_cnt);
endinterface

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: delayed train of NPULSE trigger pulses with programmable width and period
module trigger_sequencer #(parameter int B = 32, parameter int NB = 16) (
  input logic aclk,
  input logic areset,
  trigger_sequencer_if.slave io
);
  typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, FINISH} state_t;
  localparam logic [B-1:0] MAX = '1;
  state_t st;
  logic start_d;
  logic [B-1:0] cnt, w_r, l_r, w_s, p_s;
  logic [NB-1:0] np_r;
  // Width at least 1, period at least width+1 unless width is already saturated
  always_comb begin
    w_s = (io.WIDTH_REG == '0) ? B'(1) : io.WIDTH_REG;
    p_s = (io.PERIOD_REG <= w_s) ? ((w_s == MAX) ? MAX : w_s + 1'b1) : io.PERIOD_REG;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      st <= IDLE;
      start_d <= 1'b0;
      cnt <= '0;
      w_r <= '0;
      l_r <= '0;
      np_r <= '0;
      io.trig <= 1'b0;
      io.busy <= 1'b0;
      io.done <= 1'b0;
      io.pulse_cnt <= '0;
    end else begin
      start_d <= io.start;
      io.done <= 1'b0;
      if (io.stop && st != IDLE) begin
        st <= IDLE;
        io.trig <= 1'b0;
        io.busy <= 1'b0;
      end else begin
        case (st)
          IDLE: if (io.start && !start_d && !io.stop) begin
            w_r <= w_s;
            l_r <= p_s - w_s;
            np_r <= io.NPULSE_REG;
            io.pulse_cnt <= '0;
            io.busy <= 1'b1;
            if (io.DELAY_REG != '0) begin
              st <= DELAY;
              cnt <= io.DELAY_REG - 1'b1;
            end else if (io.NPULSE_REG == '0) begin
              st <= FINISH;
              io.done <= 1'b1;
              io.busy <= 1'b0;
            end else begin
              st <= HIGH;
              io.trig <= 1'b1;
              io.pulse_cnt <= NB'(1);
              cnt <= w_s - 1'b1;
            end
          end
          DELAY: if (cnt != '0) cnt <= cnt - 1'b1;
          else if (np_r == '0) begin
            st <= FINISH;
            io.done <= 1'b1;
            io.busy <= 1'b0;
          end else begin
            st <= HIGH;
            io.trig <= 1'b1;
            io.pulse_cnt <= io.pulse_cnt + 1'b1;
            cnt <= w_r - 1'b1;
          end
          HIGH: if (cnt != '0) cnt <= cnt - 1'b1;
          else if (io.pulse_cnt == np_r) begin
            st <= FINISH;
            io.done <= 1'b1;
            io.busy <= 1'b0;
            io.trig <= 1'b0;
          end else if (l_r == '0) begin
            io.pulse_cnt <= io.pulse_cnt + 1'b1;
            cnt <= w_r - 1'b1;
          end else begin
            st <= LOW;
            io.trig <= 1'b0;
            cnt <= l_r - 1'b1;
          end
          LOW: if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            st <= HIGH;
            io.trig <= 1'b1;
            io.pulse_cnt <= io.pulse_cnt + 1'b1;
            cnt <= w_r - 1'b1;
          end
          FINISH: st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule
